// File: rtl/prog_sequencer.sv
// Program sequencer: PC, IDLE/RUN/HALT run control, optional return stack, retired-instruction counter.
// Optional return stack is built when PROG_SEQ_RETSTACK_EN is defined.
module prog_sequencer #(
   parameter int          PW       = 10,
   parameter int          OW       = 6,
   parameter int          SD       = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Done,
   input  logic          Stall,
   input  logic          JmpEq,
   input  logic          JmpNe,
   input  logic          Zero,
   input  logic          OffsetEn,
   input  logic [OW-1:0] Offset,
   input  logic          AbsEn,
   input  logic [PW-1:0] AbsTarget,
   input  logic          Call,
   input  logic          Ret,
   output logic [PW-1:0] ProgCtr,
   output logic          Running,
   output logic          Ack,
   output logic          StackErr,
   output logic [15:0]   InstCount
);

   localparam logic [PW-1:0] RST_PC = PW'(RESET_PC);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] pc_q, pc_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [PW-1:0] pc_inc;
   logic [PW-1:0] off_ext;
   logic          taken;

   assign pc_inc  = pc_q + 1'b1;
   assign off_ext = PW'($signed(Offset));
   assign taken   = (JmpEq & Zero) | (JmpNe & ~Zero) | (~JmpEq & ~JmpNe);

`ifdef PROG_SEQ_RETSTACK_EN
   // Pointer counts occupied entries, so it needs one extra bit to represent "full".
   localparam int SPW = $clog2(SD) + 1;

   logic [PW-1:0]  stack_q [SD];
   logic [SPW-1:0] sp_q, sp_d, sp_m1;
   logic           err_q, err_d;
   logic           push;

   assign sp_m1 = sp_q - 1'b1;

   always_ff @(posedge Clk) begin
      if (push) stack_q[sp_q[SPW-2:0]] <= pc_inc;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end

   assign StackErr = err_q;
`else
   logic unused_flow;
   assign unused_flow = Call ^ Ret;
   assign StackErr    = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= RST_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
`ifdef PROG_SEQ_RETSTACK_EN
      sp_d    = sp_q;
      err_d   = err_q;
      push    = 1'b0;
`endif
      if (Start) begin
         state_d = S_RUN;
         pc_d    = RST_PC;
         cnt_d   = '0;
`ifdef PROG_SEQ_RETSTACK_EN
         sp_d    = '0;
         err_d   = 1'b0;
`endif
      end else if (state_q == S_RUN && !Stall) begin
         cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
         if (Done) begin
            state_d = S_HALT;
         end else begin
`ifdef PROG_SEQ_RETSTACK_EN
            if (Ret) begin
               if (sp_q != '0) begin
                  pc_d = stack_q[sp_m1[SPW-2:0]];
                  sp_d = sp_m1;
               end else begin
                  err_d = 1'b1;
                  pc_d  = pc_inc;
               end
            end else if (Call) begin
               pc_d = AbsTarget;
               if (sp_q == SPW'(SD)) begin
                  err_d = 1'b1;
               end else begin
                  push = 1'b1;
                  sp_d = sp_q + 1'b1;
               end
            end else
`endif
            if (AbsEn)                pc_d = AbsTarget;
            else if (OffsetEn && taken) pc_d = pc_q + off_ext;
            else                      pc_d = pc_inc;
         end
      end
   end

   assign ProgCtr   = pc_q;
   assign Running   = (state_q == S_RUN);
   assign Ack       = (state_q == S_HALT);
   assign InstCount = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer (default parameters).
module tb_prog_sequencer;

   logic        Clk = 1'b0;
   logic        Reset, Start, Done, Stall, JmpEq, JmpNe, Zero, OffsetEn, AbsEn, Call, Ret;
   logic [5:0]  Offset;
   logic [9:0]  AbsTarget;
   logic [9:0]  ProgCtr;
   logic        Running, Ack, StackErr;
   logic [15:0] InstCount;

   int checks = 0;
   int errors = 0;

   prog_sequencer #(.PW(10), .OW(6), .SD(4), .RESET_PC(0)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Done(Done), .Stall(Stall),
      .JmpEq(JmpEq), .JmpNe(JmpNe), .Zero(Zero), .OffsetEn(OffsetEn), .Offset(Offset),
      .AbsEn(AbsEn), .AbsTarget(AbsTarget), .Call(Call), .Ret(Ret),
      .ProgCtr(ProgCtr), .Running(Running), .Ack(Ack), .StackErr(StackErr),
      .InstCount(InstCount)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_in();
      Start = 0; Done = 0; Stall = 0; JmpEq = 0; JmpNe = 0; Zero = 0;
      OffsetEn = 0; Offset = '0; AbsEn = 0; AbsTarget = '0; Call = 0; Ret = 0;
   endtask

   task automatic jump(input logic [9:0] t);
      clear_in(); AbsEn = 1; AbsTarget = t;
      tick();
      clear_in();
   endtask

   initial begin
      clear_in();
      Reset = 1;
      repeat (2) tick();
      check("rst_pc", ProgCtr, 0);
      check("rst_run", Running, 0);
      check("rst_ack", Ack, 0);
      check("rst_cnt", InstCount, 0);
      check("rst_err", StackErr, 0);
      Reset = 0;
      tick();
      check("idle_pc", ProgCtr, 0);
      check("idle_run", Running, 0);

      // Launch and plain counting
      Start = 1; tick(); Start = 0;
      check("launch_pc", ProgCtr, 0);
      check("launch_run", Running, 1);
      check("launch_cnt", InstCount, 0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("seq_pc", ProgCtr, i);
      end
      Done = 1; tick(); Done = 0;
      check("halt_ack", Ack, 1);
      check("halt_run", Running, 0);
      check("halt_pc", ProgCtr, 5);
      check("halt_cnt", InstCount, 6);
      tick();
      check("halt_hold_pc", ProgCtr, 5);
      check("halt_hold_cnt", InstCount, 6);

      // Relaunch from HALT, Start held two cycles
      Start = 1; tick();
      check("relaunch_ack", Ack, 0);
      check("relaunch_pc", ProgCtr, 0);
      tick(); Start = 0;
      check("start_hold_pc", ProgCtr, 0);
      check("start_hold_cnt", InstCount, 0);

      // Conditional relative branches
      jump(20);
      OffsetEn = 1; JmpNe = 1; Zero = 0; Offset = 6'h3C; tick(); clear_in();
      check("bne_taken", ProgCtr, 16);
      jump(20);
      OffsetEn = 1; JmpNe = 1; Zero = 1; Offset = 6'h3C; tick(); clear_in();
      check("bne_not_taken", ProgCtr, 21);
      check("branch_cnt", InstCount, 4);
      OffsetEn = 1; JmpEq = 1; JmpNe = 1; Zero = 1; Offset = 6'd2; tick(); clear_in();
      check("both_cond", ProgCtr, 23);
      OffsetEn = 1; Zero = 1; Offset = 6'd3; tick(); clear_in();
      check("uncond_rel", ProgCtr, 26);
      OffsetEn = 1; JmpEq = 1; Zero = 1; Offset = 6'h3A; tick(); clear_in();
      check("beq_taken", ProgCtr, 20);
      OffsetEn = 1; JmpEq = 1; Zero = 0; Offset = 6'h3A; tick(); clear_in();
      check("beq_not_taken", ProgCtr, 21);
      check("cond_cnt", InstCount, 8);

      // Wrap boundaries
      jump(1023);
      tick();
      check("wrap_plain", ProgCtr, 0);
      jump(1020);
      OffsetEn = 1; Offset = 6'd8; tick(); clear_in();
      check("wrap_rel", ProgCtr, 4);
      check("wrap_cnt", InstCount, 12);

      // Stall: hold PC and count, ignore stalled Done
      jump(7);
      for (int i = 0; i < 3; i++) begin
         Stall = 1; AbsEn = 1; AbsTarget = 50; Done = (i == 2);
         tick();
         check("stall_pc", ProgCtr, 7);
         check("stall_cnt", InstCount, 13);
      end
      check("stall_done_ignored", Running, 1);
      clear_in(); AbsEn = 1; AbsTarget = 50; tick(); clear_in();
      check("unstall_pc", ProgCtr, 50);
      check("unstall_cnt", InstCount, 14);

      // Absolute jump outranks relative branch
      AbsEn = 1; AbsTarget = 200; OffsetEn = 1; Offset = 6'd5; tick(); clear_in();
      check("abs_prio", ProgCtr, 200);

`ifdef PROG_SEQ_RETSTACK_EN
      jump(10);
      for (int i = 0; i < 5; i++) begin
         Call = 1; AbsTarget = 100; tick(); clear_in();
         check("call_pc", ProgCtr, 100);
         check("call_err", StackErr, (i == 4) ? 1 : 0);
      end
      for (int i = 0; i < 4; i++) begin
         Ret = 1; tick(); clear_in();
         check("ret_pc", ProgCtr, (i == 3) ? 11 : 101);
      end
      Ret = 1; tick(); clear_in();
      check("ret_empty_pc", ProgCtr, 12);
      check("ret_empty_err", StackErr, 1);
`else
      Call = 1; AbsTarget = 300; tick(); clear_in();
      check("call_ignored_pc", ProgCtr, 201);
      Ret = 1; tick(); clear_in();
      check("ret_ignored_pc", ProgCtr, 202);
      check("no_stack_err", StackErr, 0);
`endif

      // Start in RUN beats Stall and flow inputs
      Start = 1; Stall = 1; AbsEn = 1; AbsTarget = 77; tick(); clear_in();
      check("run_restart_pc", ProgCtr, 0);
      check("run_restart_cnt", InstCount, 0);
      check("run_restart_err", StackErr, 0);

      // Asynchronous reset between edges
      jump(33);
      check("pre_reset_pc", ProgCtr, 33);
      #2 Reset = 1;
      #1;
      check("async_pc", ProgCtr, 0);
      check("async_run", Running, 0);
      check("async_ack", Ack, 0);
      check("async_cnt", InstCount, 0);
      tick();
      Reset = 0;
      tick();
      check("post_reset_idle", Running, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Parametrised program sequencer for the next-generation BasicProcessor core. It replaces the fixed 10-bit program counter and the top-level Start/Ack run logic. It adds:
- configurable PC width and signed branch-offset width
- absolute jumps
- a stall input
- a hardware call/return stack
- a saturating retired-instruction counter

It sits between the control decoder, which drives its branch and flow inputs, and the instruction ROM, which consumes `ProgCtr`.

## Interface
Parameters:
- `PW`, 10, PC width in bits (instruction ROM depth is 2**`PW`).
- `OW`, 6, width of the signed relative branch offset.
- `SD`, 4, return-stack depth in entries (power of two, at least 2).
- `RESET_PC`, 0, PC value at reset and at each program launch.

Ports (clock and reset first):
- `Clk` input 1: single clock, posedge.
- `Reset` input 1: asynchronous, active-high.
- `Start` input 1: launch the program (level-sampled).
- `Done` input 1: halt request from the decoder.
- `Stall` input 1: freeze the PC and the counter for this cycle.
- `JmpEq` input 1: branch if `Zero`.
- `JmpNe` input 1: branch if not `Zero`.
- `Zero` input 1: ALU zero flag.
- `OffsetEn` input 1: relative branch request.
- `Offset` input `OW`: two's-complement branch offset.
- `AbsEn` input 1: absolute jump request.
- `AbsTarget` input `PW`: jump/call target.
- `Call` input 1: push the return address, then jump to `AbsTarget`.
- `Ret` input 1: pop the return address into the PC.
- `ProgCtr` output `PW`: registered PC.
- `Running` output 1: high in RUN.
- `Ack` output 1: done flag, high in HALT.
- `StackErr` output 1: sticky overflow/underflow flag.
- `InstCount` output 16: retired-instruction count.

## Operation
States:
- IDLE (after reset)
- RUN
- HALT

Transitions:
- IDLE or HALT with `Start`=1: go to RUN. Also load `ProgCtr`=`RESET_PC`, clear the stack pointer, `StackErr` and `InstCount`.
- While `Start` stays high, the block remains at `RESET_PC` and does not execute. RUN begins advancing on the first cycle after `Start` falls.
- RUN with `Done`=1 and `Stall`=0: go to HALT. The PC holds and the halting instruction is counted.
- RUN with `Start`=1: relaunch exactly as from IDLE. `Start` has priority over all other inputs.

Next-PC selection in RUN (`Stall`=0, `Done`=0, `Start`=0), highest priority first:
1. `Ret`:
   - stack non-empty: pop; PC = popped value.
   - stack empty: set `StackErr`; PC = PC+1.
2. `Call`:
   - push PC+1; PC = `AbsTarget`.
   - stack full: the push is dropped and `StackErr` is set, but the jump is still taken.
   - `Call` with `Ret` asserted in the same cycle: `Ret` wins and `Call` is ignored.
3. `AbsEn`: PC = `AbsTarget`.
4. `OffsetEn` with a taken condition: PC = PC + sign-extended `Offset`, modulo 2**`PW`.
   - Taken = (`JmpEq` & `Zero`) | (`JmpNe` & !`Zero`) | (!`JmpEq` & !`JmpNe`), i.e. unconditional when neither condition bit is set.
   - If both `JmpEq` and `JmpNe` are set, the branch is always taken.
5. Otherwise PC = PC+1, wrapping from 2**`PW`-1 to 0.

Counter:
- `InstCount` increments on every RUN cycle with `Stall`=0.
- It saturates at 16'hFFFF and holds in IDLE and HALT.

## Timing
- `ProgCtr`, state, stack, `StackErr` and `InstCount` are all registered.
- Flow inputs are combinational from the decoder in the same cycle. The new PC appears one `Clk` edge later, giving single-cycle fetch.
- `Ack` rises on the edge that enters HALT and falls on the edge that leaves HALT on `Start`.
- `Running` = state==RUN.
- `Stall`=1 in RUN: all registers hold, including `Done` handling (a stalled `Done` is ignored).
- `Reset` asserted at any time, including mid-branch or mid-call, takes effect immediately and asynchronously:
  - state IDLE
  - `ProgCtr`=`RESET_PC`
  - stack empty
  - `Running`=0, `Ack`=0, `StackErr`=0, `InstCount`=0
- Stack contents need no reset; only the pointer is reset.

## Configuration
- `PROG_SEQ_RETSTACK_EN` defined: the return stack and `Call`/`Ret` behave as above.
- Not defined:
  - no stack storage is built.
  - `Call` and `Ret` are ignored, so priority continues from `AbsEn`.
  - `StackErr` is tied to 0.

## Test plan
- Reset, then `Start` high for 1 cycle, then 5 plain cycles: `ProgCtr` goes 0,1,2,3,4,5. Assert `Done` at PC=5: `Ack`=1 next cycle, PC holds 5, `InstCount`=6.
- At PC=20, `OffsetEn`=1, `JmpNe`=1, `Zero`=0, `Offset`=6'h3C (-4): PC=16. Same with `Zero`=1: PC=21.
- `PW`=10, PC=1023 plain: PC=0. PC=1020 with `Offset`=+8: PC=4.
- With the macro defined, `SD`=4: issue 5 nested `Call`s to 100 from PC=10: `StackErr`=1 on the fifth and PC=100. Then 4 `Ret`s pop in LIFO order. A fifth `Ret` gives PC+1 and `StackErr` stays 1.
- Assert `Stall` for 3 cycles at PC=7 with `AbsEn`=1, target 50: PC holds 7 and the count is unchanged. First unstalled cycle: PC=50.
- Assert `Reset` mid-RUN at PC=33 between clock edges: `ProgCtr`=0, `Running`=0, `Ack`=0 immediately, before the next edge.
